data_mem_responder: RTL and testbench

- Memory-side responder for the core's data-memory port. It services each load/store request with a configurable number of wait states, returning data on data_i and signalling wait states on data_stall.
- Contains a word-organised RAM with byte-lane write enables.
- Flags accesses outside its window on data_err.
- Sits between the core's data port and the SoC data RAM region.

---
 rtl/data_mem_responder.sv | 114 +++++++++++
 tb/tb_data_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with byte-lane writes and a window/range check.
// Latency: READ_WAIT/WRITE_WAIT stall cycles, then completion; load data is registered and appears the next cycle.
// Backpressure: data_stall is combinational and holds the core while wait states are counted down.
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_WAIT   = 0,
  parameter int          WRITE_WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_mem,
  input  logic        wmem_o,
  input  logic [31:0] addr_o,
  input  logic [31:0] data_o,
  input  logic [3:0]  wmask,
  output logic [31:0] data_i,
  output logic        data_stall,
  output logic        data_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [3:0]    wait_sel;
  logic          stall_c;
  logic          complete_c;
  logic          done;

  // Offset is wrapping, so addresses below the base land far above the window.
  assign offset   = addr_o - ADDR_BASE;
  assign in_range = {1'b0, offset} < WIN_BYTES;
  assign word_idx = offset[AW+1:2];
  assign wait_sel = wmem_o ? 4'(WRITE_WAIT) : 4'(READ_WAIT);

  // Reset forces the stall low and blocks any completion, including a pending write.
  assign done       = complete_c & reset;
  assign data_stall = stall_c & reset;
  assign data_i     = data_q;
  assign data_err   = err_q;

  // Next-state logic: count wait states, complete when the counter is spent, abort on a dropped request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_mem) begin
          if (wait_sel == 4'd0) begin
            complete_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = wait_sel - 4'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req_mem) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          complete_c = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, wait counter, load data and the one-cycle fault pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= done & ~in_range;
      if (done && !wmem_o && in_range) begin
        data_q <= mem_q[word_idx];
      end
    end
  end

  // RAM byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (done && wmem_o && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem_q[word_idx][8*i +: 8] <= data_o[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances with different wait-state settings.
// Table vectors and a randomized run against a word-array model on the zero-wait instance.
// Hand sequences cover stall counts, flush, out-of-range and reset during a wait.
module tb_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, req_c;
  logic        wmem;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic [31:0] di_a, di_b, di_c;
  logic        stall_a, stall_b, stall_c;
  logic        err_a, err_b, err_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_WAIT(0), .WRITE_WAIT(0)) u_a (
    .clk(clk), .reset(reset), .req_mem(req_a), .wmem_o(wmem), .addr_o(addr), .data_o(wdata),
    .wmask(wmask), .data_i(di_a), .data_stall(stall_a), .data_err(err_a));

  data_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_WAIT(3), .WRITE_WAIT(2)) u_b (
    .clk(clk), .reset(reset), .req_mem(req_b), .wmem_o(wmem), .addr_o(addr), .data_o(wdata),
    .wmask(wmask), .data_i(di_b), .data_stall(stall_b), .data_err(err_b));

  data_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .READ_WAIT(0), .WRITE_WAIT(4)) u_c (
    .clk(clk), .reset(reset), .req_mem(req_c), .wmem_o(wmem), .addr_o(addr), .data_o(wdata),
    .wmask(wmask), .data_i(di_c), .data_stall(stall_c), .data_err(err_c));

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp_di;
    logic        exp_err;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic [31:0] edi, input logic eerr);
    vec_t v;
    v.req = rq; v.wr = wr; v.addr = a; v.d = d; v.m = m; v.exp_di = edi; v.exp_err = eerr;
    return v;
  endfunction

  task automatic set_req(input int which, input logic v);
    case (which)
      0: req_a = v;
      1: req_b = v;
      default: req_c = v;
    endcase
  endtask

  function automatic logic stall_of(input int which);
    case (which)
      0: return stall_a;
      1: return stall_b;
      default: return stall_c;
    endcase
  endfunction

  // Hold a request until the stall drops, count stall cycles (bounded), finish in cycle C+1.
  task automatic access(input int which, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int stalls);
    wmem = wr; addr = a; wdata = d; wmask = m;
    set_req(which, 1'b1);
    stalls = 0;
    #1;
    while (stall_of(which) && stalls < 40) begin
      stalls++;
      tick();
    end
    tick();
    set_req(which, 1'b0);
  endtask

  // Reference model for instance A: plain word array plus last-load register.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_di;
  logic        model_err;

  task automatic model_access(input logic rq, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m);
    logic [31:0] off;
    int idx;
    model_err = 1'b0;
    if (rq) begin
      off = a - BASE;
      if (off < 32'(DEPTH * 4)) begin
        idx = int'(off / 4);
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (m[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end else begin
          model_di = model_mem[idx];
        end
      end else begin
        model_err = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic rq, wr;
    logic [31:0] a, d;
    logic [3:0] m;

    tbl[0]  = mk(1, 1, BASE + 32'h00, 32'hCAFEF00D, 4'hF, 32'h0000_0000, 0);
    tbl[1]  = mk(1, 1, BASE + 32'h3C, 32'h0F0F0F0F, 4'hF, 32'h0000_0000, 0);
    tbl[2]  = mk(1, 1, BASE + 32'h08, 32'hDEADBEEF, 4'hF, 32'h0000_0000, 0);
    tbl[3]  = mk(1, 0, BASE + 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 0);
    tbl[4]  = mk(1, 1, BASE + 32'h0C, 32'h11223344, 4'hF, 32'hDEADBEEF, 0);
    tbl[5]  = mk(1, 1, BASE + 32'h0C, 32'hAA000000, 4'h8, 32'hDEADBEEF, 0);
    tbl[6]  = mk(1, 0, BASE + 32'h0C, 32'h0,        4'h0, 32'hAA223344, 0);
    tbl[7]  = mk(1, 1, BASE + 32'h0D, 32'h000000BB, 4'h1, 32'hAA223344, 0);
    tbl[8]  = mk(1, 0, BASE + 32'h0F, 32'h0,        4'h0, 32'hAA2233BB, 0);
    tbl[9]  = mk(1, 1, BASE + 32'h08, 32'hFFFFFFFF, 4'h0, 32'hAA2233BB, 0);
    tbl[10] = mk(1, 0, BASE + 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 0);
    tbl[11] = mk(1, 0, BASE + 32'h40, 32'h0,        4'h0, 32'hDEADBEEF, 1);
    tbl[12] = mk(1, 1, BASE + 32'h40, 32'h55555555, 4'hF, 32'hDEADBEEF, 1);
    tbl[13] = mk(1, 1, 32'h0FFF_FFFC, 32'h66666666, 4'hF, 32'hDEADBEEF, 1);
    tbl[14] = mk(1, 0, BASE + 32'h00, 32'h0,        4'h0, 32'hCAFEF00D, 0);
    tbl[15] = mk(1, 0, BASE + 32'h3C, 32'h0,        4'h0, 32'h0F0F0F0F, 0);
    tbl[16] = mk(1, 0, 32'h0000_0000, 32'h0,        4'h0, 32'h0F0F0F0F, 1);
    tbl[17] = mk(1, 1, BASE + 32'h3C, 32'h00FF0000, 4'h4, 32'h0F0F0F0F, 0);
    tbl[18] = mk(1, 0, BASE + 32'h3C, 32'h0,        4'h0, 32'h0FFF0F0F, 0);
    tbl[19] = mk(0, 0, BASE + 32'h00, 32'h0,        4'h0, 32'h0FFF0F0F, 0);

    // Reset: outputs quiet even with a request pending on the wait-state instance.
    reset = 1'b1; req_a = 0; req_b = 0; req_c = 0;
    wmem = 0; addr = BASE; wdata = 0; wmask = 0;
    #2 reset = 1'b0;
    req_b = 1'b1;
    #3;
    chk("rst_stall_b", 32'(stall_b), 0);
    chk("rst_di_a", di_a, 0);
    chk("rst_di_b", di_b, 0);
    chk("rst_err_a", 32'(err_a), 0);
    req_b = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Zero-wait instance: back-to-back table vectors, one access per cycle.
    foreach (tbl[i]) begin
      req_a = tbl[i].req; wmem = tbl[i].wr; addr = tbl[i].addr; wdata = tbl[i].d; wmask = tbl[i].m;
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(stall_a), 0);
      tick();
      chk($sformatf("tbl%0d_di", i), di_a, tbl[i].exp_di);
      chk($sformatf("tbl%0d_err", i), 32'(err_a), 32'(tbl[i].exp_err));
    end
    req_a = 1'b0;

    // Randomized run on the zero-wait instance against the model.
    model_di = 32'h0FFF0F0F;
    for (int i = 0; i < 360; i++) begin
      if (i < DEPTH) begin
        rq = 1; wr = 1; a = BASE + 32'(i * 4); m = 4'hF;
      end else begin
        rq = ($urandom % 4) != 0;
        wr = $urandom % 2;
        a  = BASE + 32'(int'($urandom_range(0, 111)) - 24);
        m  = 4'($urandom);
      end
      d = $urandom;
      req_a = rq; wmem = wr; addr = a; wdata = d; wmask = m;
      #1;
      chk("rnd_stall", 32'(stall_a), 0);
      tick();
      model_access(rq, wr, a, d, m);
      chk("rnd_di", di_a, model_di);
      chk("rnd_err", 32'(err_a), 32'(model_err));
    end
    req_a = 1'b0;

    // READ_WAIT=3 / WRITE_WAIT=2 instance.
    access(1, 1, BASE + 32'h14, 32'h12345678, 4'hF, st);
    chk("b_store_stalls", st, 2);
    chk("b_store_di", di_b, 0);
    access(1, 0, BASE + 32'h14, 32'h0, 4'h0, st);
    chk("b_load_stalls", st, 3);
    chk("b_load_di", di_b, 32'h12345678);
    chk("b_load_err", 32'(err_b), 0);
    access(1, 0, BASE + 32'h40, 32'h0, 4'h0, st);
    chk("b_oor_stalls", st, 3);
    chk("b_oor_err", 32'(err_b), 1);
    chk("b_oor_di", di_b, 32'h12345678);
    tick();
    chk("b_oor_err_end", 32'(err_b), 0);
    access(1, 1, BASE - 32'h4, 32'hFFFFFFFF, 4'hF, st);
    chk("b_oor_st_err", 32'(err_b), 1);

    // Flush: drop the store request after one stall cycle.
    wmem = 1; addr = BASE + 32'h14; wdata = 32'hFFFFFFFF; wmask = 4'hF; req_b = 1;
    #1;
    chk("b_flush_stall1", 32'(stall_b), 1);
    tick();
    chk("b_flush_stall2", 32'(stall_b), 1);
    req_b = 0;
    #1;
    chk("b_flush_drop", 32'(stall_b), 0);
    tick();
    access(1, 0, BASE + 32'h14, 32'h0, 4'h0, st);
    chk("b_after_flush_stalls", st, 3);
    chk("b_after_flush_di", di_b, 32'h12345678);

    // WRITE_WAIT=4 instance, then reset in the middle of a store's wait.
    access(2, 1, BASE + 32'h20, 32'h0BADCAFE, 4'hF, st);
    chk("c_store_stalls", st, 4);
    access(2, 0, BASE + 32'h20, 32'h0, 4'h0, st);
    chk("c_load_stalls", st, 0);
    chk("c_load_di", di_c, 32'h0BADCAFE);
    wmem = 1; addr = BASE + 32'h20; wdata = 32'hFFFF0000; wmask = 4'hF; req_c = 1;
    tick(); tick();
    #1;
    chk("c_wait_stall", 32'(stall_c), 1);
    reset = 1'b0;
    #1;
    chk("c_rst_stall", 32'(stall_c), 0);
    chk("c_rst_di", di_c, 0);
    chk("c_rst_err", 32'(err_c), 0);
    tick();
    req_c = 0;
    tick();
    reset = 1'b1;
    tick();
    access(2, 0, BASE + 32'h20, 32'h0, 4'h0, st);
    chk("c_post_rst_stalls", st, 0);
    chk("c_post_rst_di", di_c, 32'h0BADCAFE);
    access(0, 0, BASE + 32'h08, 32'h0, 4'h0, st);
    chk("a_post_rst_di", di_a, model_mem[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
